// File: rtl/debug_dump_ctrl.sv
// debug_dump_ctrl: walks PC, the register file and the first N_MEM_WORDS data
// memory words, handing each one to the UART as a single 32-bit transfer.
// Optional build macro DUMP_CHECKSUM_EN appends one final word holding the
// modulo-2^NB_DATA sum of every word sent before it.
module debug_dump_ctrl #(
    parameter int unsigned NB_DATA        = 32,
    parameter int unsigned NB_REG_ADDRESS = 5,
    parameter int unsigned NB_MEM_ADDRESS = 7,
    parameter int unsigned N_MEM_WORDS    = 32
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic                      i_start,
    input  logic [NB_DATA-1:0]        i_read_pc,
    input  logic [NB_DATA-1:0]        i_debug_read_reg,
    input  logic [NB_DATA-1:0]        i_debug_read_mem,
    input  logic                      i_tx_done_32b_word,
    output logic [NB_REG_ADDRESS-1:0] o_debug_read_reg_address,
    output logic [NB_MEM_ADDRESS-1:0] o_debug_read_mem_address,
    output logic [NB_DATA-1:0]        o_data_to_send,
    output logic                      o_enable_uart_send_data,
    output logic                      o_busy,
    output logic                      o_done
);

    localparam int unsigned N_REGS   = 2 ** NB_REG_ADDRESS;
`ifdef DUMP_CHECKSUM_EN
    localparam int unsigned N_EXTRA  = 1;
`else
    localparam int unsigned N_EXTRA  = 0;
`endif
    localparam int unsigned N_ITEMS  = 1 + N_REGS + N_MEM_WORDS + N_EXTRA;
    localparam int unsigned NB_IDX   = $clog2(N_ITEMS);
    // Item index layout: 0 = PC, 1..N_REGS = registers, then memory words.
    localparam int unsigned REG_LAST = N_REGS;
    localparam int unsigned MEM_BASE = N_REGS + 1;
    localparam int unsigned MEM_LAST = N_REGS + N_MEM_WORDS;
    localparam int unsigned LAST_IDX = N_ITEMS - 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SET_ADDR,
        ST_LATCH,
        ST_SEND,
        ST_WAIT_TX,
        ST_DONE
    } state_t;

    state_t                    state, state_next;
    logic [NB_IDX-1:0]         idx, idx_next;
    logic [NB_REG_ADDRESS-1:0] reg_addr, reg_addr_next;
    logic [NB_MEM_ADDRESS-1:0] mem_addr, mem_addr_next;
    logic [NB_DATA-1:0]        data, data_next;
    logic                      send, send_next;
    logic                      busy, busy_next;
    logic                      done, done_next;
    logic [NB_DATA-1:0]        sel_word;
`ifdef DUMP_CHECKSUM_EN
    logic [NB_DATA-1:0]        csum, csum_next;
    logic                      sel_is_data;
`endif

    // Source mux for the word belonging to the current item index.
    always_comb begin
        sel_word = i_read_pc;
`ifdef DUMP_CHECKSUM_EN
        sel_is_data = 1'b1;
`endif
        if (idx == '0) begin
            sel_word = i_read_pc;
        end else if (idx <= NB_IDX'(REG_LAST)) begin
            sel_word = i_debug_read_reg;
`ifdef DUMP_CHECKSUM_EN
        end else if (idx <= NB_IDX'(MEM_LAST)) begin
            sel_word = i_debug_read_mem;
        end else begin
            sel_word    = csum;
            sel_is_data = 1'b0;
        end
`else
        end else begin
            sel_word = i_debug_read_mem;
        end
`endif
    end

    // Next-state, item sequencing and registered-output next values.
    always_comb begin
        state_next    = state;
        idx_next      = idx;
        reg_addr_next = reg_addr;
        mem_addr_next = mem_addr;
        data_next     = data;
`ifdef DUMP_CHECKSUM_EN
        csum_next     = csum;
`endif
        case (state)
            ST_IDLE: begin
                if (i_start) begin
                    state_next = ST_SET_ADDR;
                    idx_next   = '0;
`ifdef DUMP_CHECKSUM_EN
                    csum_next  = '0;
`endif
                end
            end
            ST_SET_ADDR: state_next = ST_LATCH;
            ST_LATCH: begin
                data_next  = sel_word;
`ifdef DUMP_CHECKSUM_EN
                if (sel_is_data) begin
                    csum_next = csum + sel_word;
                end
`endif
                state_next = ST_SEND;
            end
            ST_SEND: state_next = ST_WAIT_TX;
            ST_WAIT_TX: begin
                if (i_tx_done_32b_word) begin
                    if (idx == NB_IDX'(LAST_IDX)) begin
                        state_next = ST_DONE;
                    end else begin
                        idx_next   = idx + NB_IDX'(1);
                        state_next = ST_SET_ADDR;
                    end
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase

        // Pointers only move when a new item of their kind is addressed, so
        // each one parks on its final value once its phase is over.
        if (state_next == ST_IDLE) begin
            reg_addr_next = '0;
            mem_addr_next = '0;
        end else if (state_next == ST_SET_ADDR && state != ST_SET_ADDR) begin
            if (idx_next != '0 && idx_next <= NB_IDX'(REG_LAST)) begin
                reg_addr_next = NB_REG_ADDRESS'(idx_next - NB_IDX'(1));
            end else if (idx_next >= NB_IDX'(MEM_BASE) && idx_next <= NB_IDX'(MEM_LAST)) begin
                mem_addr_next = NB_MEM_ADDRESS'(idx_next - NB_IDX'(MEM_BASE));
            end
        end

        send_next = (state_next == ST_SEND);
        busy_next = (state_next != ST_IDLE);
        done_next = (state_next == ST_DONE);
    end

    // State and output registers.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state    <= ST_IDLE;
            idx      <= '0;
            reg_addr <= '0;
            mem_addr <= '0;
            data     <= '0;
            send     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
            csum     <= '0;
`endif
        end else begin
            state    <= state_next;
            idx      <= idx_next;
            reg_addr <= reg_addr_next;
            mem_addr <= mem_addr_next;
            data     <= data_next;
            send     <= send_next;
            busy     <= busy_next;
            done     <= done_next;
`ifdef DUMP_CHECKSUM_EN
            csum     <= csum_next;
`endif
        end
    end

    assign o_debug_read_reg_address = reg_addr;
    assign o_debug_read_mem_address = mem_addr;
    assign o_data_to_send           = data;
    assign o_enable_uart_send_data  = send;
    assign o_busy                   = busy;
    assign o_done                   = done;

endmodule

// File: tb/tb_debug_dump_ctrl.sv
// Scoreboard bench for debug_dump_ctrl: a register-file / memory model, a UART
// responder and a monitor collecting every word the DUT hands to the UART.
module tb_debug_dump_ctrl;

    localparam int unsigned NB_DATA = 32;
    localparam int unsigned NB_REG  = 5;
    localparam int unsigned NB_MEM  = 7;
    localparam int unsigned NMEM    = 32;
    localparam int unsigned NREGS   = 32;
`ifdef DUMP_CHECKSUM_EN
    localparam int unsigned NWORDS  = 1 + NREGS + NMEM + 1;
`else
    localparam int unsigned NWORDS  = 1 + NREGS + NMEM;
`endif
    localparam int BOUND = 3000;

    logic clk = 1'b0;
    logic i_reset = 1'b0;
    logic i_start = 1'b0;
    logic [NB_DATA-1:0] pc_val = 32'h10;
    logic [NB_DATA-1:0] reg_xor = '0;
    logic [NB_DATA-1:0] mem_base = 32'h100;
    logic tx_auto = 1'b0;
    logic tx_manual = 1'b0;
    logic stall = 1'b0;

    logic [NB_DATA-1:0] i_debug_read_reg, i_debug_read_mem;
    logic               i_tx_done_32b_word;
    logic [NB_REG-1:0]  o_debug_read_reg_address;
    logic [NB_MEM-1:0]  o_debug_read_mem_address;
    logic [NB_DATA-1:0] o_data_to_send;
    logic               o_enable_uart_send_data, o_busy, o_done;

    logic [NB_DATA-1:0] exp_q[$];
    logic [NB_DATA-1:0] obs_q[$];
    int n_en = 0;
    int n_done = 0;
    int checks = 0;
    int errors = 0;

    debug_dump_ctrl #(
        .NB_DATA(NB_DATA), .NB_REG_ADDRESS(NB_REG),
        .NB_MEM_ADDRESS(NB_MEM), .N_MEM_WORDS(NMEM)
    ) dut (
        .i_clock(clk),
        .i_reset(i_reset),
        .i_start(i_start),
        .i_read_pc(pc_val),
        .i_debug_read_reg(i_debug_read_reg),
        .i_debug_read_mem(i_debug_read_mem),
        .i_tx_done_32b_word(i_tx_done_32b_word),
        .o_debug_read_reg_address(o_debug_read_reg_address),
        .o_debug_read_mem_address(o_debug_read_mem_address),
        .o_data_to_send(o_data_to_send),
        .o_enable_uart_send_data(o_enable_uart_send_data),
        .o_busy(o_busy),
        .o_done(o_done)
    );

    always #5 clk = ~clk;

    assign i_debug_read_reg   = NB_DATA'(o_debug_read_reg_address) ^ reg_xor;
    assign i_debug_read_mem   = mem_base + NB_DATA'(o_debug_read_mem_address);
    assign i_tx_done_32b_word = tx_auto | tx_manual;

    // Monitor: record each word handed to the UART and each completion pulse.
    always @(negedge clk) begin
        if (o_enable_uart_send_data) begin
            obs_q.push_back(o_data_to_send);
            n_en <= n_en + 1;
        end
        if (o_done) n_done <= n_done + 1;
    end

    // UART responder: tx_done three cycles after each enable unless stalled.
    initial begin
        forever begin
            @(negedge clk);
            if (o_enable_uart_send_data && !stall) begin
                repeat (2) @(negedge clk);
                tx_auto = 1'b1;
                @(negedge clk);
                tx_auto = 1'b0;
            end
        end
    end

    task automatic push_expected();
        logic [NB_DATA-1:0] sum;
        logic [NB_DATA-1:0] v;
        exp_q.push_back(pc_val);
        sum = pc_val;
        for (int k = 0; k < int'(NREGS); k++) begin
            v = NB_DATA'(k) ^ reg_xor;
            exp_q.push_back(v);
            sum = sum + v;
        end
        for (int i = 0; i < int'(NMEM); i++) begin
            v = mem_base + NB_DATA'(i);
            exp_q.push_back(v);
            sum = sum + v;
        end
`ifdef DUMP_CHECKSUM_EN
        exp_q.push_back(sum);
`endif
    endtask

    task automatic pulse_start();
        @(negedge clk);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic wait_done(input int base, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < BOUND; c++) begin
            @(posedge clk);
            if (n_done > base) begin
                ok = 1'b1;
                break;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        #1 i_reset = 1'b1;
        #1;
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", o_busy); end
        checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", o_done); end
        checks++; if (o_enable_uart_send_data !== 1'b0) begin errors++; $display("FAIL reset_enable got %b want 0", o_enable_uart_send_data); end
        checks++; if (o_data_to_send !== '0) begin errors++; $display("FAIL reset_data got %h want 0", o_data_to_send); end
        checks++; if (o_debug_read_reg_address !== '0) begin errors++; $display("FAIL reset_reg_addr got %h want 0", o_debug_read_reg_address); end
        checks++; if (o_debug_read_mem_address !== '0) begin errors++; $display("FAIL reset_mem_addr got %h want 0", o_debug_read_mem_address); end
        repeat (2) @(negedge clk);
        i_reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_full_dump(input logic [NB_DATA-1:0] pc, input logic [NB_DATA-1:0] rx, input logic [NB_DATA-1:0] mb);
        bit ok;
        int base_en, base_done;
        logic [NB_DATA-1:0] got, want;
        pc_val = pc; reg_xor = rx; mem_base = mb;
        base_en = n_en; base_done = n_done;
        push_expected();
        pulse_start();
        checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL dump_busy_after_start got %b want 1", o_busy); end
        wait_done(base_done, ok);
        checks++; if (!ok) begin errors++; $display("FAIL dump_timeout done_count %0d want %0d", n_done, base_done + 1); end
        checks++; if (n_en - base_en != int'(NWORDS)) begin errors++; $display("FAIL dump_enable_count got %0d want %0d", n_en - base_en, NWORDS); end
        checks++; if (o_busy !== 1'b0 || o_debug_read_reg_address !== '0 || o_debug_read_mem_address !== '0) begin
            errors++; $display("FAIL dump_idle_after got busy=%b reg=%h mem=%h want 0 0 0", o_busy, o_debug_read_reg_address, o_debug_read_mem_address); end
        while (obs_q.size() > 0) begin
            got = obs_q.pop_front();
            checks++;
            if (exp_q.size() == 0) begin errors++; $display("FAIL dump_word extra got %h want none", got); end
            else begin
                want = exp_q.pop_front();
                if (got !== want) begin errors++; $display("FAIL dump_word got %h want %h", got, want); end
            end
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL dump_missing got %0d words short want 0", exp_q.size()); end
        exp_q.delete();
        repeat (20) @(negedge clk);
        checks++; if (n_done != base_done + 1) begin errors++; $display("FAIL dump_done_count got %0d want %0d", n_done - base_done, 1); end
    endtask

    task automatic test_stall();
        bit ok;
        int base_en, base_done, c;
        logic [NB_DATA-1:0] got, want;
        pc_val = 32'h10; reg_xor = '0; mem_base = 32'h100;
        base_en = n_en; base_done = n_done;
        stall = 1'b1;
        push_expected();
        pulse_start();
        for (c = 0; c < 100 && n_en == base_en; c++) @(posedge clk);
        checks++; if (n_en != base_en + 1) begin errors++; $display("FAIL stall_first_enable got %0d want 1", n_en - base_en); end
        repeat (1000) @(negedge clk);
        checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL stall_busy got %b want 1", o_busy); end
        checks++; if (n_en != base_en + 1) begin errors++; $display("FAIL stall_extra_enable got %0d want 1", n_en - base_en); end
        checks++; if (n_done != base_done) begin errors++; $display("FAIL stall_done got %0d want 0", n_done - base_done); end
        stall = 1'b0;
        tx_manual = 1'b1;
        @(negedge clk);
        tx_manual = 1'b0;
        wait_done(base_done, ok);
        checks++; if (!ok) begin errors++; $display("FAIL stall_timeout done_count %0d want %0d", n_done, base_done + 1); end
        while (obs_q.size() > 0) begin
            got = obs_q.pop_front();
            checks++;
            if (exp_q.size() == 0) begin errors++; $display("FAIL stall_word extra got %h want none", got); end
            else begin
                want = exp_q.pop_front();
                if (got !== want) begin errors++; $display("FAIL stall_word got %h want %h", got, want); end
            end
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL stall_missing got %0d words short want 0", exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_spurious();
        bit ok;
        int base_en, base_done;
        logic [NB_DATA-1:0] got, want;
        pc_val = 32'hCAFE_0001; reg_xor = 32'h0000_5A00; mem_base = 32'h8000_0000;
        base_en = n_en; base_done = n_done;
        @(negedge clk); tx_manual = 1'b1;
        @(negedge clk); tx_manual = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (o_busy !== 1'b0 || n_en != base_en) begin errors++; $display("FAIL spur_idle_tx got busy=%b en=%0d want 0 0", o_busy, n_en - base_en); end
        push_expected();
        @(negedge clk); i_start = 1'b1; tx_manual = 1'b1;
        @(negedge clk); i_start = 1'b0; tx_manual = 1'b0;
        checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL spur_start_with_tx got %b want 1", o_busy); end
        for (int p = 0; p < 5; p++) begin
            repeat (37) @(negedge clk);
            i_start = 1'b1;
            @(negedge clk);
            i_start = 1'b0;
        end
        wait_done(base_done, ok);
        checks++; if (!ok) begin errors++; $display("FAIL spur_timeout done_count %0d want %0d", n_done, base_done + 1); end
        repeat (30) @(negedge clk);
        checks++; if (n_done != base_done + 1) begin errors++; $display("FAIL spur_dump_count got %0d want 1", n_done - base_done); end
        checks++; if (n_en != base_en + int'(NWORDS)) begin errors++; $display("FAIL spur_enable_count got %0d want %0d", n_en - base_en, NWORDS); end
        while (obs_q.size() > 0) begin
            got = obs_q.pop_front();
            checks++;
            if (exp_q.size() == 0) begin errors++; $display("FAIL spur_word extra got %h want none", got); end
            else begin
                want = exp_q.pop_front();
                if (got !== want) begin errors++; $display("FAIL spur_word got %h want %h", got, want); end
            end
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL spur_missing got %0d words short want 0", exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_reset_mid();
        bit ok;
        int base_en, base_done, c;
        logic [NB_DATA-1:0] got, want;
        pc_val = 32'h10; reg_xor = '0; mem_base = 32'h100;
        base_en = n_en;
        push_expected();
        pulse_start();
        for (c = 0; c < BOUND && n_en < base_en + 10; c++) @(posedge clk);
        checks++; if (n_en != base_en + 10) begin errors++; $display("FAIL rstmid_reach_10 got %0d want 10", n_en - base_en); end
        @(posedge clk);
        #2 i_reset = 1'b1;
        #1;
        checks++; if (o_busy !== 1'b0 || o_done !== 1'b0 || o_enable_uart_send_data !== 1'b0) begin
            errors++; $display("FAIL rstmid_flags got busy=%b done=%b en=%b want 0 0 0", o_busy, o_done, o_enable_uart_send_data); end
        checks++; if (o_data_to_send !== '0 || o_debug_read_reg_address !== '0 || o_debug_read_mem_address !== '0) begin
            errors++; $display("FAIL rstmid_data got data=%h reg=%h mem=%h want 0 0 0", o_data_to_send, o_debug_read_reg_address, o_debug_read_mem_address); end
        repeat (2) @(negedge clk);
        i_reset = 1'b0;
        base_en = n_en;
        repeat (10) @(negedge clk);
        checks++; if (o_busy !== 1'b0 || n_en != base_en) begin errors++; $display("FAIL rstmid_no_resume got busy=%b en=%0d want 0 0", o_busy, n_en - base_en); end
        exp_q.delete();
        obs_q.delete();
        pc_val = 32'h0000_0055;
        base_done = n_done;
        push_expected();
        pulse_start();
        wait_done(base_done, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rstmid_timeout done_count %0d want %0d", n_done, base_done + 1); end
        checks++; if (obs_q.size() == 0 || obs_q[0] !== 32'h0000_0055) begin
            errors++; $display("FAIL rstmid_first_is_pc got %h want %h", (obs_q.size() == 0) ? 32'hx : obs_q[0], 32'h55); end
        while (obs_q.size() > 0) begin
            got = obs_q.pop_front();
            checks++;
            if (exp_q.size() == 0) begin errors++; $display("FAIL rstmid_word extra got %h want none", got); end
            else begin
                want = exp_q.pop_front();
                if (got !== want) begin errors++; $display("FAIL rstmid_word got %h want %h", got, want); end
            end
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rstmid_missing got %0d words short want 0", exp_q.size()); end
        exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_full_dump(32'h10, 32'h0, 32'h100);
        test_full_dump(32'hDEAD_BEEF, 32'hFFFF_0000, 32'h1234_0000);
        test_stall();
        test_spurious();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/debug_dump_ctrl.md
DEBUG_DUMP_CTRL -- requirements
Module: debug_dump_ctrl

Interface
REQ-001 The block SHALL have parameter NB_DATA, default 32, width of every dumped word.
REQ-002 The block SHALL have parameter NB_REG_ADDRESS, default 5, register-file address width; 2^NB_REG_ADDRESS registers are dumped.
REQ-003 The block SHALL have parameter NB_MEM_ADDRESS, default 7, data-memory word-address width.
REQ-004 The block SHALL have parameter N_MEM_WORDS, default 32, number of memory words dumped; legal range 1..2^NB_MEM_ADDRESS.
REQ-005 The block SHALL have port i_clock, input, 1, the single clock; all logic on its rising edge.
REQ-006 The block SHALL have port i_reset, input, 1, asynchronous active-high reset.
REQ-007 The block SHALL have port i_start, input, 1, request to begin one dump, sampled only in IDLE.
REQ-008 The block SHALL have port i_read_pc, input, NB_DATA, current PC value.
REQ-009 The block SHALL have port i_debug_read_reg, input, NB_DATA, register-file data for o_debug_read_reg_address.
REQ-010 The block SHALL have port i_debug_read_mem, input, NB_DATA, data-memory word for o_debug_read_mem_address.
REQ-011 The block SHALL have port i_tx_done_32b_word, input, 1, one-cycle pulse from the UART when a 32-bit word has been fully sent.
REQ-012 The block SHALL have port o_debug_read_reg_address, output, NB_REG_ADDRESS, register read pointer.
REQ-013 The block SHALL have port o_debug_read_mem_address, output, NB_MEM_ADDRESS, memory read pointer.
REQ-014 The block SHALL have port o_data_to_send, output, NB_DATA, registered word handed to the UART.
REQ-015 The block SHALL have port o_enable_uart_send_data, output, 1, one-cycle pulse starting a 32-bit UART transmission.
REQ-016 The block SHALL have port o_busy, output, 1, high in every state except IDLE.
REQ-017 The block SHALL have port o_done, output, 1, one-cycle pulse when the dump completes.

Function
REQ-018 The FSM SHALL have states IDLE, SET_ADDR, LATCH, SEND, WAIT_TX, DONE; item order: PC, reg 0..2^NB_REG_ADDRESS-1, mem 0..N_MEM_WORDS-1 (65 words at defaults).
REQ-019 IDLE with i_start=1 at edge T SHALL enter SET_ADDR at T+1 with item index 0; o_busy high from T+1.
REQ-020 SET_ADDR SHALL drive the address of the current item for one cycle, then LATCH; reads are treated as one-cycle latency.
REQ-021 LATCH SHALL register the selected source (i_read_pc, i_debug_read_reg or i_debug_read_mem) into o_data_to_send, then SEND.
REQ-022 SEND SHALL assert o_enable_uart_send_data for exactly one cycle, then WAIT_TX; o_data_to_send held stable until the next LATCH.
REQ-023 WAIT_TX SHALL remain until i_tx_done_32b_word=1, with no timeout; then SET_ADDR for the next item, or DONE after the last item.
REQ-024 DONE SHALL assert o_done for one cycle and return to IDLE; address outputs return to 0 in IDLE.
REQ-025 Address counters SHALL never wrap: the reg pointer stops at its maximum and the mem pointer stops at N_MEM_WORDS-1 when that phase ends.
REQ-026 i_start outside IDLE and i_tx_done_32b_word outside WAIT_TX SHALL be ignored.
REQ-027 Simultaneous i_start and i_tx_done_32b_word in IDLE SHALL start a dump; the done pulse is discarded.

Reset
REQ-028 i_reset=1 SHALL immediately force IDLE, item index 0, both addresses 0, o_data_to_send 0, and o_enable_uart_send_data, o_busy, o_done 0, including mid-dump; no pending send is resumed.

Configuration
REQ-029 With DUMP_CHECKSUM_EN defined, the block SHALL accumulate the modulo-2^NB_DATA sum of all sent words and send it as one extra final word before DONE (66 words at defaults); the accumulator clears on entering SET_ADDR from IDLE.
REQ-030 Without DUMP_CHECKSUM_EN, no accumulator SHALL exist and the dump ends after the last memory word.

Verification
REQ-031 Reset values: assert i_reset without a clock edge -> all outputs 0 asynchronously.
REQ-032 Full dump: PC=0x10, reg[k]=k, mem[i]=0x100+i, tx_done 3 cycles after each enable -> 65 enables in order 0x10, 0..31, 0x100..0x11F; one o_done.
REQ-033 Stall: tx_done withheld 1000 cycles after the first enable -> stays in WAIT_TX, o_busy=1, no second enable.
REQ-034 Spurious inputs: i_start pulsed while busy and tx_done pulsed in IDLE -> no extra enables; dump count unchanged.
REQ-035 Reset mid-dump after the 10th enable -> outputs return to 0; next i_start begins again with PC.
REQ-036 DUMP_CHECKSUM_EN with REQ-032 data -> 66th word 0x000023F0 (16+496+8688), then o_done.
